// File: rtl/synth_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared constants and types for the synthesizer SPI front end.
//               Frame length, note commands, field bit positions inside the
//               56-bit frame, and the receiver FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int SPI_FRAME_BITS = 56;

    localparam logic [7:0] CMD_NOTE_ON  = 8'h90;
    localparam logic [7:0] CMD_NOTE_OFF = 8'h80;

    // Field positions inside the frame; byte0 lands in the top byte.
    localparam int CMD_MSB         = 55;
    localparam int CMD_LSB         = 48;
    localparam int VOICE_MSB       = 47;
    localparam int VOICE_LSB       = 40;
    localparam int VEL_IGNORED_BIT = 39;
    localparam int VEL_MSB         = 38;
    localparam int VEL_LSB         = 32;
    localparam int TUNING_MSB      = 31;
    localparam int TUNING_LSB      = 0;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_READY     = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_CHECK     = 2'd3
    } spi_rx_state_t;

endpackage : synth_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for one asynchronous input bit.
// Ports       : i_clk     - destination clock
//               i_reset_n - asynchronous active-low reset (output clears to 0)
//               i_d       - asynchronous input
//               o_q       - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/spi_note_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_note_receiver
// Description : SPI mode-0 slave that receives 7-byte note-event frames from
//               the host MCU, oversampled in the i_clk domain, and presents
//               validated note events to voice_controller as a one-cycle flag
//               plus held fields. MISO returns the frame error count.
// Ports       : i_clk, i_reset_n       - system clock, async active-low reset
//               i_spi_sck/cs_n/mosi    - asynchronous SPI pins
//               o_spi_miso             - error-count status byte, MSB first
//               o_SPI_flag             - one-cycle valid-frame pulse
//               o_SPI_note_status      - 1 = note on, 0 = note off
//               o_SPI_voice_index      - target voice
//               o_SPI_velocity         - MIDI velocity
//               o_SPI_tuning_code      - DDS phase increment
//               o_frame_errors         - saturating rejected-frame count
// Revision    : 1.0 - initial release
// ============================================================================
module spi_note_receiver
    import synth_pkg::*;
#(
    parameter int CLK_PER_SCK_MIN = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_spi_sck,
    input  logic        i_spi_cs_n,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic        o_SPI_flag,
    output logic        o_SPI_note_status,
    output logic [7:0]  o_SPI_voice_index,
    output logic [6:0]  o_SPI_velocity,
    output logic [31:0] o_SPI_tuning_code,
    output logic [7:0]  o_frame_errors
);

    localparam logic [5:0] c_bit_cnt_sat = 6'd57;
    localparam logic [5:0] c_frame_bits  = 6'(SPI_FRAME_BITS);

    logic w_sck_s;
    logic w_cs_s;
    logic w_mosi_s;

    sync_2ff u_sync_sck  (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_spi_sck),  .o_q(w_sck_s));
    sync_2ff u_sync_cs   (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_spi_cs_n), .o_q(w_cs_s));
    sync_2ff u_sync_mosi (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_spi_mosi), .o_q(w_mosi_s));

    spi_rx_state_t             r_state;
    logic                      r_sck_d;
    logic                      r_cs_d;
    logic [SPI_FRAME_BITS-1:0] r_shift;
    logic [5:0]                r_bit_cnt;
    logic [7:0]                r_miso_sr;
    logic                      r_flag;
    logic                      r_note_status;
    logic [7:0]                r_voice;
    logic [6:0]                r_velocity;
    logic [31:0]               r_tuning;
    logic [7:0]                r_frame_errors;

    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_cs_rise;
    logic       w_cs_fall;
    logic [7:0] w_cmd;
    logic       w_frame_valid;
    logic [7:0] w_errors_sat;
    logic [7:0] w_errors_next;
    logic       w_unused_vel_bit7;

    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_cs_rise  = w_cs_s & ~r_cs_d;
    assign w_cs_fall  = ~w_cs_s & r_cs_d;

    assign w_cmd         = r_shift[CMD_MSB:CMD_LSB];
    assign w_frame_valid = (r_bit_cnt == c_frame_bits) &&
                           ((w_cmd == CMD_NOTE_ON) || (w_cmd == CMD_NOTE_OFF));

    // Velocity byte bit 7 carries no information.
    assign w_unused_vel_bit7 = r_shift[VEL_IGNORED_BIT];

    assign w_errors_sat  = (r_frame_errors == 8'hFF) ? r_frame_errors : r_frame_errors + 8'd1;
    // A CS fall landing in CHECK must report the count including the frame
    // being rejected in that same cycle, so MISO loads from the next value.
    assign w_errors_next = ((r_state == ST_CHECK) && !w_frame_valid) ? w_errors_sat : r_frame_errors;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_WAIT_IDLE;
            r_sck_d        <= 1'b0;
            r_cs_d         <= 1'b0;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_miso_sr      <= '0;
            r_flag         <= 1'b0;
            r_note_status  <= 1'b0;
            r_voice        <= '0;
            r_velocity     <= '0;
            r_tuning       <= '0;
            r_frame_errors <= '0;
        end else begin
            r_sck_d <= w_sck_s;
            r_cs_d  <= w_cs_s;
            r_flag  <= 1'b0;

            case (r_state)
                // Synchronized CS resets low, so a frame already in flight at
                // reset release is skipped until the host deselects.
                ST_WAIT_IDLE: begin
                    r_miso_sr <= '0;
                    if (w_cs_s) begin
                        r_state <= ST_READY;
                    end
                end

                ST_READY: begin
                    if (w_cs_fall) begin
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        r_miso_sr <= w_errors_next;
                        r_state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        r_miso_sr <= '0;
                        r_state   <= ST_CHECK;
                    end else begin
                        if (w_sck_rise) begin
                            r_shift <= {r_shift[SPI_FRAME_BITS-2:0], w_mosi_s};
                            if (r_bit_cnt != c_bit_cnt_sat) begin
                                r_bit_cnt <= r_bit_cnt + 6'd1;
                            end
                        end
                        // Zeros fill in behind the status byte.
                        if (w_sck_fall) begin
                            r_miso_sr <= {r_miso_sr[6:0], 1'b0};
                        end
                    end
                end

                ST_CHECK: begin
                    r_frame_errors <= w_errors_next;
                    if (w_frame_valid) begin
                        r_flag        <= 1'b1;
                        r_note_status <= (w_cmd == CMD_NOTE_ON);
                        r_voice       <= r_shift[VOICE_MSB:VOICE_LSB];
                        r_velocity    <= r_shift[VEL_MSB:VEL_LSB];
                        r_tuning      <= r_shift[TUNING_MSB:TUNING_LSB];
                    end
                    if (w_cs_fall) begin
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        r_miso_sr <= w_errors_next;
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_state <= ST_READY;
                    end
                end

                default: r_state <= ST_WAIT_IDLE;
            endcase
        end
    end

    assign o_spi_miso        = r_miso_sr[7];
    assign o_SPI_flag        = r_flag;
    assign o_SPI_note_status = r_note_status;
    assign o_SPI_voice_index = r_voice;
    assign o_SPI_velocity    = r_velocity;
    assign o_SPI_tuning_code = r_tuning;
    assign o_frame_errors    = r_frame_errors;

`ifndef SYNTHESIS
    // SCK high phase, measured in synchronized samples, must cover at least
    // half the minimum SCK period less one sample of edge uncertainty.
    logic [7:0] r_sck_phase;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sck_phase <= '0;
        end else if (w_sck_rise || w_sck_fall) begin
            r_sck_phase <= '0;
        end else if (r_sck_phase != 8'hFF) begin
            r_sck_phase <= r_sck_phase + 8'd1;
        end
    end

    always @(posedge i_clk) begin
        if (i_reset_n && (r_state == ST_SHIFT) && w_sck_fall) begin
            assert (r_sck_phase >= 8'(CLK_PER_SCK_MIN / 2 - 1))
                else $error("spi_note_receiver: SCK high phase too short");
        end
    end
`endif

endmodule : spi_note_receiver
`default_nettype wire

// File: tb/tb_spi_note_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_note_receiver
// Description : Directed self-checking bench for spi_note_receiver. 50 MHz
//               system clock, 2 MHz SCK, hand-computed expected fields.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_note_receiver;

    localparam int c_sck_half_ns = 250;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        spi_sck  = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        flag;
    logic        note_status;
    logic [7:0]  voice_index;
    logic [6:0]  velocity;
    logic [31:0] tuning_code;
    logic [7:0]  frame_errors;

    int vectors     = 0;
    int miscompares = 0;
    int flag_count  = 0;

    spi_note_receiver #(.CLK_PER_SCK_MIN(8)) dut (
        .i_clk             (clk),
        .i_reset_n         (reset_n),
        .i_spi_sck         (spi_sck),
        .i_spi_cs_n        (spi_cs_n),
        .i_spi_mosi        (spi_mosi),
        .o_spi_miso        (spi_miso),
        .o_SPI_flag        (flag),
        .o_SPI_note_status (note_status),
        .o_SPI_voice_index (voice_index),
        .o_SPI_velocity    (velocity),
        .o_SPI_tuning_code (tuning_code),
        .o_frame_errors    (frame_errors)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (flag === 1'b1) flag_count++;
    end

    // Frame data is left-aligned in 64 bits; bit index i is data[63-i].
    task automatic shift_bits(input logic [63:0] data, input int first, input int nbits);
        for (int i = first; i < first + nbits; i++) begin
            spi_mosi = data[63-i];
            #(c_sck_half_ns);
            spi_sck = 1'b1;
            #(c_sck_half_ns);
            spi_sck = 1'b0;
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        spi_cs_n = 1'b0;
    endtask

    task automatic end_frame();
        #(c_sck_half_ns);
        @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] data, input int nbits);
        start_frame();
        shift_bits(data, 0, nbits);
        end_frame();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (flag !== 1'b0) begin miscompares++; $display("FAIL reset_flag: got %b want 0", flag); end
        vectors++; if (note_status !== 1'b0) begin miscompares++; $display("FAIL reset_status: got %b want 0", note_status); end
        vectors++; if (voice_index !== 8'd0) begin miscompares++; $display("FAIL reset_voice: got %0d want 0", voice_index); end
        vectors++; if (velocity !== 7'd0) begin miscompares++; $display("FAIL reset_velocity: got %0d want 0", velocity); end
        vectors++; if (tuning_code !== 32'd0) begin miscompares++; $display("FAIL reset_tuning: got %h want 0", tuning_code); end
        vectors++; if (frame_errors !== 8'd0) begin miscompares++; $display("FAIL reset_errors: got %0d want 0", frame_errors); end
        vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_note_on();
        start_frame();
        shift_bits(64'h90_05_64_01_31_2D_00_00, 0, 56);
        #(c_sck_half_ns);
        @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (flag !== 1'b0) begin miscompares++; $display("FAIL flag_early: got %b want 0 at edge 3", flag); end
        @(posedge clk);
        #1;
        vectors++; if (flag !== 1'b1) begin miscompares++; $display("FAIL flag_edge4: got %b want 1", flag); end
        vectors++; if (note_status !== 1'b1) begin miscompares++; $display("FAIL on_status: got %b want 1", note_status); end
        vectors++; if (voice_index !== 8'd5) begin miscompares++; $display("FAIL on_voice: got %0d want 5", voice_index); end
        vectors++; if (velocity !== 7'd100) begin miscompares++; $display("FAIL on_velocity: got %0d want 100", velocity); end
        vectors++; if (tuning_code !== 32'd20_000_000) begin miscompares++; $display("FAIL on_tuning: got %0d want 20000000", tuning_code); end
        @(posedge clk);
        #1;
        vectors++; if (flag !== 1'b0) begin miscompares++; $display("FAIL flag_width: got %b want 0 at edge 5", flag); end
        repeat (6) @(posedge clk);
        #1;
        vectors++; if (flag_count !== 1) begin miscompares++; $display("FAIL on_flag_count: got %0d want 1", flag_count); end
        vectors++; if (frame_errors !== 8'd0) begin miscompares++; $display("FAIL on_errors: got %0d want 0", frame_errors); end
        vectors++; if (tuning_code !== 32'd20_000_000) begin miscompares++; $display("FAIL on_hold: got %0d want 20000000", tuning_code); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = flag_count;
        start_frame();
        shift_bits(64'h90_06_7F_03_93_87_00_00, 0, 56);
        #(c_sck_half_ns);
        @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        vectors++; if (voice_index !== 8'd6) begin miscompares++; $display("FAIL b2b1_voice: got %0d want 6", voice_index); end
        vectors++; if (velocity !== 7'd127) begin miscompares++; $display("FAIL b2b1_velocity: got %0d want 127", velocity); end
        vectors++; if (tuning_code !== 32'h0393_8700) begin miscompares++; $display("FAIL b2b1_tuning: got %h want 03938700", tuning_code); end
        spi_cs_n = 1'b0;
        shift_bits(64'h80_05_00_00_00_00_00_00, 0, 56);
        end_frame();
        vectors++; if (flag_count - base !== 2) begin miscompares++; $display("FAIL b2b_flags: got %0d want 2", flag_count - base); end
        vectors++; if (note_status !== 1'b0) begin miscompares++; $display("FAIL b2b2_status: got %b want 0", note_status); end
        vectors++; if (voice_index !== 8'd5) begin miscompares++; $display("FAIL b2b2_voice: got %0d want 5", voice_index); end
        vectors++; if (velocity !== 7'd0) begin miscompares++; $display("FAIL b2b2_velocity: got %0d want 0", velocity); end
        vectors++; if (tuning_code !== 32'd0) begin miscompares++; $display("FAIL b2b2_tuning: got %h want 0", tuning_code); end
        vectors++; if (frame_errors !== 8'd0) begin miscompares++; $display("FAIL b2b_errors: got %0d want 0", frame_errors); end
    endtask

    task automatic test_bad_frames();
        int base;
        base = flag_count;
        send_frame(64'h90_05_64_01_31_2D_00_00, 48);
        vectors++; if (frame_errors !== 8'd1) begin miscompares++; $display("FAIL short_errors: got %0d want 1", frame_errors); end
        send_frame(64'h90_05_64_01_31_2D_00_00, 64);
        vectors++; if (frame_errors !== 8'd2) begin miscompares++; $display("FAIL long_errors: got %0d want 2", frame_errors); end
        send_frame(64'hA0_05_64_01_31_2D_00_00, 56);
        vectors++; if (frame_errors !== 8'd3) begin miscompares++; $display("FAIL badcmd_errors: got %0d want 3", frame_errors); end
        vectors++; if (flag_count - base !== 0) begin miscompares++; $display("FAIL bad_flags: got %0d want 0", flag_count - base); end
        vectors++; if (note_status !== 1'b0) begin miscompares++; $display("FAIL bad_status: got %b want 0", note_status); end
        vectors++; if (voice_index !== 8'd5) begin miscompares++; $display("FAIL bad_voice: got %0d want 5", voice_index); end
        vectors++; if (velocity !== 7'd0) begin miscompares++; $display("FAIL bad_velocity: got %0d want 0", velocity); end
        vectors++; if (tuning_code !== 32'd0) begin miscompares++; $display("FAIL bad_tuning: got %h want 0", tuning_code); end
    endtask

    task automatic test_miso();
        logic [63:0] data;
        logic [7:0]  status;
        logic        exp_bit;
        data   = 64'h90_07_40_00_00_10_00_00;
        status = 8'd3;
        start_frame();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (spi_miso !== status[7]) begin miscompares++; $display("FAIL miso_msb_3clk: got %b want %b", spi_miso, status[7]); end
        for (int i = 0; i < 56; i++) begin
            spi_mosi = data[63-i];
            #(c_sck_half_ns);
            exp_bit = (i < 8) ? status[7-i] : 1'b0;
            vectors++; if (spi_miso !== exp_bit) begin miscompares++; $display("FAIL miso_bit%0d: got %b want %b", i, spi_miso, exp_bit); end
            spi_sck = 1'b1;
            #(c_sck_half_ns);
            spi_sck = 1'b0;
        end
        end_frame();
        vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL miso_idle: got %b want 0", spi_miso); end
        vectors++; if (voice_index !== 8'd7) begin miscompares++; $display("FAIL miso_voice: got %0d want 7", voice_index); end
        vectors++; if (velocity !== 7'd64) begin miscompares++; $display("FAIL miso_velocity: got %0d want 64", velocity); end
        vectors++; if (tuning_code !== 32'h0000_1000) begin miscompares++; $display("FAIL miso_tuning: got %h want 00001000", tuning_code); end
        vectors++; if (frame_errors !== 8'd3) begin miscompares++; $display("FAIL miso_errors: got %0d want 3", frame_errors); end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] data;
        int base;
        data = 64'h90_0A_20_11_22_33_44_00;
        base = flag_count;
        start_frame();
        shift_bits(data, 0, 28);
        #100;
        reset_n = 1'b0;
        #5;
        vectors++; if (voice_index !== 8'd0) begin miscompares++; $display("FAIL midrst_voice: got %0d want 0", voice_index); end
        vectors++; if (tuning_code !== 32'd0) begin miscompares++; $display("FAIL midrst_tuning: got %h want 0", tuning_code); end
        vectors++; if (frame_errors !== 8'd0) begin miscompares++; $display("FAIL midrst_errors: got %0d want 0", frame_errors); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        shift_bits(data, 28, 28);
        end_frame();
        vectors++; if (flag_count - base !== 0) begin miscompares++; $display("FAIL midrst_flags: got %0d want 0", flag_count - base); end
        vectors++; if (note_status !== 1'b0) begin miscompares++; $display("FAIL midrst_status: got %b want 0", note_status); end
        vectors++; if (voice_index !== 8'd0) begin miscompares++; $display("FAIL midrst_voice_after: got %0d want 0", voice_index); end
        vectors++; if (velocity !== 7'd0) begin miscompares++; $display("FAIL midrst_velocity: got %0d want 0", velocity); end
        vectors++; if (frame_errors !== 8'd0) begin miscompares++; $display("FAIL midrst_errors_after: got %0d want 0", frame_errors); end
        send_frame(64'h90_0B_FF_12_34_56_78_00, 56);
        vectors++; if (flag_count - base !== 1) begin miscompares++; $display("FAIL recover_flags: got %0d want 1", flag_count - base); end
        vectors++; if (note_status !== 1'b1) begin miscompares++; $display("FAIL recover_status: got %b want 1", note_status); end
        vectors++; if (voice_index !== 8'd11) begin miscompares++; $display("FAIL recover_voice: got %0d want 11", voice_index); end
        vectors++; if (velocity !== 7'd127) begin miscompares++; $display("FAIL recover_velocity: got %0d want 127", velocity); end
        vectors++; if (tuning_code !== 32'h1234_5678) begin miscompares++; $display("FAIL recover_tuning: got %h want 12345678", tuning_code); end
    endtask

    task automatic test_error_saturation();
        int base;
        base = flag_count;
        for (int n = 0; n < 260; n++) begin
            @(negedge clk);
            spi_cs_n = 1'b0;
            repeat (8) @(negedge clk);
            spi_cs_n = 1'b1;
            repeat (8) @(negedge clk);
            if (n == 253) begin
                #1;
                vectors++; if (frame_errors !== 8'd254) begin miscompares++; $display("FAIL sat_254: got %0d want 254", frame_errors); end
            end
            if (n == 254) begin
                #1;
                vectors++; if (frame_errors !== 8'd255) begin miscompares++; $display("FAIL sat_255: got %0d want 255", frame_errors); end
            end
        end
        #1;
        vectors++; if (frame_errors !== 8'd255) begin miscompares++; $display("FAIL sat_hold: got %0d want 255", frame_errors); end
        vectors++; if (flag_count - base !== 0) begin miscompares++; $display("FAIL sat_flags: got %0d want 0", flag_count - base); end
        vectors++; if (voice_index !== 8'd11) begin miscompares++; $display("FAIL sat_voice: got %0d want 11", voice_index); end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_back_to_back();
        test_bad_frames();
        test_miso();
        test_reset_mid_frame();
        test_error_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_spi_note_receiver
`default_nettype wire
